// File: rtl/delta_sigma_pkg.sv
// Shared constants for the sinc^3 bitstream decimator: filter shape, pipeline depth,
// warm-up length and width/midscale helpers.
package delta_sigma_pkg;

  localparam int CIC_ORDER     = 3;
  localparam int COMB_DELAY    = 1;
  localparam int WARMUP_FRAMES = 3;
  localparam int PIPE_LATENCY  = 4;

  // Bit growth of an order-3 CIC is 3*log2(R); one extra bit holds exactly R^3.
  function automatic int cic_width(input int log2r);
    return CIC_ORDER * log2r + 1;
  endfunction

  function automatic int midscale(input int msb);
    return 1 << (msb - 1);
  endfunction

endpackage

// File: rtl/delta_sigma_decimator_comb_stage.sv
// One CIC comb section: registered first difference against the value seen at the
// previous enable, with differential delay 1.
module decim_comb_stage #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      dout <= '0;
    end else if (en) begin
      dout <= din - prev;
      prev <= din;
    end
  end

endmodule

// File: rtl/delta_sigma_decimator.sv
// 1-bit delta-sigma bitstream to offset-binary PCM via a sinc^3 decimator, R = 2**LOG2R.
// Optional macro DECIM_SAT_EN adds the SAT port and clamps a full-scale result.
module delta_sigma_decimator
  import delta_sigma_pkg::*;
#(
  parameter int MSB   = 16,
  parameter int LOG2R = 6
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           DSMin,
  input  logic           DSMen,
  output logic [MSB-1:0] PCMout,
  output logic           PCMvalid
`ifdef DECIM_SAT_EN
  ,
  output logic           SAT
`endif
);

  localparam int W      = cic_width(LOG2R);
  localparam int SH     = CIC_ORDER * LOG2R - MSB;
  localparam int WARM_W = $clog2(WARMUP_FRAMES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP_FRAMES);
  localparam logic [MSB-1:0]    MID       = MSB'(midscale(MSB));

  logic [W-1:0]              integ1, integ2, integ3, cap;
  logic [LOG2R-1:0]          frame_cnt;
  logic [WARM_W-1:0]         warm_cnt;
  logic                      emit;
  logic [PIPE_LATENCY-1:0]   vld_pipe;
  logic                      strobe;
  logic [CIC_ORDER:0][W-1:0] comb_d;

  assign strobe = DSMen && (&frame_cnt);

  // Integrators read last cycle's upstream value, so the captured I3 is I3+I2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      integ1    <= '0;
      integ2    <= '0;
      integ3    <= '0;
      cap       <= '0;
      frame_cnt <= '0;
      warm_cnt  <= '0;
      emit      <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LATENCY-2:0], strobe};
      if (DSMen) begin
        integ1    <= integ1 + W'(DSMin);
        integ2    <= integ2 + integ1;
        integ3    <= integ3 + integ2;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (strobe) begin
        cap  <= integ3 + integ2;
        emit <= (warm_cnt == WARM_DONE);
        if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  assign comb_d[0] = cap;

  for (genvar s = 0; s < CIC_ORDER; s++) begin : g_comb
    decim_comb_stage #(.W(W)) u_stage (
      .clk  (CLK),
      .rst  (RESET),
      .en   (vld_pipe[s]),
      .din  (comb_d[s]),
      .dout (comb_d[s+1])
    );
  end

  logic [W-1:0]   res;
  logic [MSB-1:0] scaled;
  logic           fire;
  logic           unused_res;

  assign res        = comb_d[CIC_ORDER];
  assign scaled     = res[SH +: MSB];
  assign fire       = vld_pipe[PIPE_LATENCY-1] & emit;
  assign unused_res = ^res;

`ifdef DECIM_SAT_EN
  // Only R^3 sets the top bit, so it alone marks the full-scale clamp case.
  logic clamp;
  assign clamp = res[W-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PCMout   <= MID;
      PCMvalid <= 1'b0;
      SAT      <= 1'b0;
    end else begin
      PCMvalid <= fire;
      SAT      <= fire & clamp;
      if (fire) PCMout <= clamp ? '1 : scaled;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PCMout   <= MID;
      PCMvalid <= 1'b0;
    end else begin
      PCMvalid <= fire;
      if (fire) PCMout <= scaled;
    end
  end
`endif

endmodule

// File: tb/tb_delta_sigma_decimator.sv
// Bench for delta_sigma_decimator: table of bitstream patterns with a frame-counting
// scoreboard, plus hand sequences for first-output timing and mid-pipeline reset.
module tb_delta_sigma_decimator;

  localparam int MSB   = 16;
  localparam int LOG2R = 6;
  localparam int R     = 1 << LOG2R;

  logic           CLK   = 1'b0;
  logic           RESET = 1'b1;
  logic           DSMin = 1'b0;
  logic           DSMen = 1'b0;
  logic [MSB-1:0] PCMout;
  logic           PCMvalid;
`ifdef DECIM_SAT_EN
  logic           SAT;
`endif

  delta_sigma_decimator #(.MSB(MSB), .LOG2R(LOG2R)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DSMin    (DSMin),
    .DSMen    (DSMen),
    .PCMout   (PCMout),
    .PCMvalid (PCMvalid)
`ifdef DECIM_SAT_EN
    ,
    .SAT      (SAT)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [MSB-1:0] pcm;
    logic           sat;
    int             due;
  } exp_t;

  typedef struct {
    int             kind;    // 0 zeros, 1 alternating 1/0, 2 ones, 3 modulator loopback 0x4000
    int             period;  // DSMen high once every 'period' cycles
    int             frames;
    logic [MSB-1:0] pcm;
    logic           sat;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Bench-side stimulus/frame model state.
  int             bits, cnt, frame, ph, release_cyc, first_valid, got;
  logic [MSB-1:0] acc;

  // Monitor / scoreboard consumer, sampled away from the active edge.
  exp_t e;
  logic prev_vld = 1'b0;
  always @(negedge CLK) begin
    if (PCMvalid) begin
      got++;
      if (first_valid < 0) first_valid = cyc;
      check("valid_back_to_back", longint'(prev_vld), 0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d: PCMout=0x%0h, no sample expected", cyc, PCMout);
      end else begin
        e = sbq.pop_front();
        check("pcm_value", longint'(PCMout), longint'(e.pcm));
        check("valid_cycle", longint'(cyc), longint'(e.due));
`ifdef DECIM_SAT_EN
        check("sat_flag", longint'(SAT), longint'(e.sat));
`endif
      end
    end
`ifdef DECIM_SAT_EN
    else check("sat_idle", longint'(SAT), 0);
`endif
    prev_vld = PCMvalid;
  end

  // Reset with DSMen/DSMin high to show RESET wins over the bitstream.
  task automatic do_reset(input int ncyc);
    RESET = 1'b1;
    DSMen = 1'b1;
    DSMin = 1'b1;
    sbq.delete();
    repeat (ncyc) begin
      @(posedge CLK);
      #1;
    end
    RESET       = 1'b0;
    DSMen       = 1'b0;
    DSMin       = 1'b0;
    bits        = 0;
    cnt         = 0;
    frame       = 0;
    ph          = 0;
    acc         = '0;
    release_cyc = cyc;
    first_valid = -1;
  endtask

  // Drive until the model has seen 'upto' frame strobes; the last strobe edge is consumed.
  task automatic drive(input int kind, input int period, input int upto,
                       input logic [MSB-1:0] pcm, input logic sat);
    while (frame < upto) begin
      if (ph == 0) begin
        DSMen = 1'b1;
        case (kind)
          0:       DSMin = 1'b0;
          1:       DSMin = (bits % 2 == 0);
          2:       DSMin = 1'b1;
          default: {DSMin, acc} = {1'b0, acc} + 17'h04000;
        endcase
        bits++;
        if (cnt == R - 1) begin
          cnt = 0;
          frame++;
          if (frame > 3) sbq.push_back('{pcm: pcm, sat: sat, due: cyc + 5});
        end else begin
          cnt++;
        end
      end else begin
        DSMen = 1'b0;
        DSMin = 1'($urandom);
      end
      ph = (ph + 1 == period) ? 0 : ph + 1;
      @(posedge CLK);
      #1;
    end
    DSMen = 1'b0;
  endtask

  task automatic drain_and_check(input int exp_valids, input int got0);
    repeat (8) begin
      @(posedge CLK);
      #1;
    end
    check("drain_queue_empty", sbq.size(), 0);
    check("valid_count", got - got0, exp_valids);
  endtask

  vec_t vecs[6];

  initial begin
    int got0;
    got = 0;
    vecs[0] = '{kind: 0, period: 1, frames: 6, pcm: 16'h0000, sat: 1'b0};
    vecs[1] = '{kind: 1, period: 1, frames: 6, pcm: 16'h8000, sat: 1'b0};
`ifdef DECIM_SAT_EN
    vecs[2] = '{kind: 2, period: 1, frames: 5, pcm: 16'hFFFF, sat: 1'b1};
`else
    vecs[2] = '{kind: 2, period: 1, frames: 5, pcm: 16'h0000, sat: 1'b0};
`endif
    vecs[3] = '{kind: 3, period: 1, frames: 6, pcm: 16'h4000, sat: 1'b0};
    vecs[4] = '{kind: 1, period: 3, frames: 5, pcm: 16'h8000, sat: 1'b0};
    vecs[5] = '{kind: 3, period: 2, frames: 5, pcm: 16'h4000, sat: 1'b0};

    for (int v = 0; v < 6; v++) begin
      do_reset(2);
      check("reset_pcmout", longint'(PCMout), 16'h8000);
      check("reset_pcmvalid", longint'(PCMvalid), 0);
`ifdef DECIM_SAT_EN
      check("reset_sat", longint'(SAT), 0);
`endif
      got0 = got;
      drive(vecs[v].kind, vecs[v].period, vecs[v].frames, vecs[v].pcm, vecs[v].sat);
      drain_and_check(vecs[v].frames - 3, got0);
      check("first_valid_latency", first_valid - release_cyc,
            (4 * R - 1) * vecs[v].period + 1 + 4);
    end

    // Reset pulse two edges after a strobe: in-flight sample dropped, warm-up restarts.
    do_reset(2);
    drive(0, 1, 5, 16'h0000, 1'b0);
    DSMen = 1'b1;
    DSMin = 1'b0;
    @(posedge CLK);
    #1;
    do_reset(1);
    check("midreset_pcmout", longint'(PCMout), 16'h8000);
    check("midreset_pcmvalid", longint'(PCMvalid), 0);
    got0 = got;
    drive(1, 1, 3, 16'h8000, 1'b0);
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    check("warmup_no_valid", got - got0, 0);
    check("warmup_pcmout_held", longint'(PCMout), 16'h8000);
    drive(1, 1, 5, 16'h8000, 1'b0);
    drain_and_check(2, got0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
